// File: rtl/uart_pkg.sv
// Shared definitions for the hex line sender: FSM encoding and ASCII constants.
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      ACK   = ST_ACK,
      DONE  = ST_DONE
   } state_t;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_nibble_ascii
   import uart_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
      else                ascii = ASCII_A + {4'h0, nibble} - 8'd10;
   end

endmodule

// File: rtl/uart_hex_sender.sv
// Sends the low NIBBLES hex digits of a latched word (MSB first, optional CR LF)
// to a byte UART, one load strobe per byte, pacing on the transmitter idle flag.
module uart_hex_sender
   import uart_pkg::*;
#(
   parameter int NIBBLES     = 8,
   parameter int APPEND_CRLF = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_value,
   input  logic        i_valid,
   output logic        o_busy,
   output logic        o_drop,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_en,
   input  logic        i_txempty,
   output logic [1:0]  o_dbg_state
);

   localparam logic [3:0] NIB_CNT  = 4'(NIBBLES);
   localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1 + 2 * APPEND_CRLF);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  data_q, data_d;
   logic        en_q, en_d;
   logic        drop_q, drop_d;

   logic [4:0]  shamt;
   logic [3:0]  nibble;
   logic [7:0]  hex_char;
   logic [7:0]  cur_char;

   // Shift amount is only meaningful while idx addresses a digit.
   always_comb begin
      shamt  = 5'((NIBBLES - 1 - int'(idx_q)) * 4);
      nibble = 4'(word_q >> shamt);
   end

   hex_nibble_ascii u_hex (
      .nibble (nibble),
      .ascii  (hex_char)
   );

   always_comb begin
      if (idx_q < NIB_CNT)       cur_char = hex_char;
      else if (idx_q == NIB_CNT) cur_char = ASCII_CR;
      else                       cur_char = ASCII_LF;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      data_d  = data_q;
      en_d    = 1'b0;
      drop_d  = i_valid && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               word_d  = i_value;
               idx_d   = 4'd0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (i_txempty) begin
               data_d  = cur_char;
               en_d    = 1'b1;
               state_d = ACK;
            end
         end
         // The idle flag is still high in the load cycle; wait for it to drop.
         ACK: begin
            if (!i_txempty) state_d = DONE;
         end
         DONE: begin
            if (i_txempty) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         word_q  <= 32'd0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         data_q  <= data_d;
         en_q    <= en_d;
         drop_q  <= drop_d;
      end
   end

   assign o_busy      = (state_q != IDLE);
   assign o_drop      = drop_q;
   assign o_tx_data   = data_q;
   assign o_tx_en     = en_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Bench for uart_hex_sender: behavioural UART models, expected-byte scoreboards.
module tb_uart_hex_sender;
   import uart_pkg::*;

   typedef logic [7:0] line_t [10];
   localparam line_t LINE_A = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
   localparam line_t LINE_B = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h46, 8'h45, 8'h44, 8'h43, 8'h0D, 8'h0A};
   localparam line_t LINE_C = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
   localparam line_t LINE_D = '{8'h30, 8'h46, 8'h31, 8'h45, 8'h32, 8'h44, 8'h33, 8'h43, 8'h0D, 8'h0A};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] value = '0, value4 = '0;
   logic        valid = 1'b0, valid4 = 1'b0;
   logic        busy, drop, tx_en, txempty;
   logic        busy4, drop4, tx_en4, txempty4;
   logic [7:0]  tx_data, tx_data4;
   logic [1:0]  dbg_state, dbg_state4;
   logic        hold = 1'b0;

   int n_tests = 0;
   int n_fail = 0;
   int tx_cnt = 0, tx_cnt4 = 0, drop_cnt = 0;
   int bit_clks = 434;

   logic [7:0] exp_q[$];
   logic [7:0] exp4_q[$];

   // clock / reset
   always #10 clk = ~clk;

   uart_hex_sender dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_value (value), .i_valid (valid),
      .o_busy (busy), .o_drop (drop), .o_tx_data (tx_data), .o_tx_en (tx_en),
      .i_txempty (txempty), .o_dbg_state (dbg_state)
   );

   uart_hex_sender #(.NIBBLES(4), .APPEND_CRLF(0)) dut4 (
      .i_clk (clk), .i_rst_n (rst_n), .i_value (value4), .i_valid (valid4),
      .o_busy (busy4), .o_drop (drop4), .o_tx_data (tx_data4), .o_tx_en (tx_en4),
      .i_txempty (txempty4), .o_dbg_state (dbg_state4)
   );

   // behavioural transmitters: idle flag falls after a load, rises after 10 bits
   logic m_empty, m_empty4;
   int   m_cnt, m_cnt4;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_empty <= 1'b1; m_cnt <= 0;
      end else if (tx_en) begin
         m_empty <= 1'b0; m_cnt <= 10 * bit_clks;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
         m_cnt <= 0; m_empty <= 1'b1;
      end
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_empty4 <= 1'b1; m_cnt4 <= 0;
      end else if (tx_en4) begin
         m_empty4 <= 1'b0; m_cnt4 <= 10 * bit_clks;
      end else if (m_cnt4 > 1) begin
         m_cnt4 <= m_cnt4 - 1;
      end else if (m_cnt4 == 1) begin
         m_cnt4 <= 0; m_empty4 <= 1'b1;
      end
   end
   assign txempty  = m_empty && !hold;
   assign txempty4 = m_empty4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitors
   logic prev_en = 1'b0, prev_en4 = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en = 1'b0;
      end else begin
         if (drop) drop_cnt++;
         if (tx_en) begin
            tx_cnt++;
            if (prev_en) check("tx_en_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) check("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
         prev_en = tx_en;
      end
   end
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en4 = 1'b0;
      end else begin
         if (tx_en4) begin
            tx_cnt4++;
            if (prev_en4) check("tx_en4_width", 32'd2, 32'd1);
            if (exp4_q.size() == 0) check("unexpected_byte4", {24'h0, tx_data4}, 32'hFFFF_FFFF);
            else check("byte4", {24'h0, tx_data4}, {24'h0, exp4_q.pop_front()});
         end
         prev_en4 = tx_en4;
      end
   end

   // driver tasks
   task automatic push_line(input line_t l);
      foreach (l[i]) exp_q.push_back(l[i]);
   endtask

   task automatic send(input logic [31:0] v);
      @(negedge clk);
      value = v; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) check(name, 32'd1, 32'd0);
   endtask

   task automatic wait_cnt(input int target, input int budget, input string name);
      int n = 0;
      while (tx_cnt < target && n < budget) begin @(negedge clk); n++; end
      if (n >= budget) check(name, tx_cnt, target);
   endtask

   initial begin
      int base;
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_drop", drop, 1'b0);
      check("rst_tx_en", tx_en, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // full line at real bit rate, plus 4-digit no-terminator variant and a dropped request
      push_line(LINE_A);
      exp4_q.push_back(8'h46); exp4_q.push_back(8'h30);
      exp4_q.push_back(8'h30); exp4_q.push_back(8'h46);
      value = 32'h1234_ABCD; valid = 1'b1;
      value4 = 32'h0000_F00F; valid4 = 1'b1;
      @(negedge clk);
      valid = 1'b0; valid4 = 1'b0;
      check("busy_after_accept", busy, 1'b1);
      repeat (99) @(negedge clk);
      send(32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      check("drop_while_busy", drop_cnt, 1);
      wait_idle(60000, "line_a_timeout");
      check("line_a_count", tx_cnt, 10);
      check("line4_count", tx_cnt4, 4);
      check("busy4_idle", busy4, 1'b0);
      check("line_a_queue_empty", exp_q.size(), 0);
      check("line4_queue_empty", exp4_q.size(), 0);

      // request in the returning cycle is dropped, the next one accepted
      bit_clks = 20;
      base = tx_cnt;
      push_line(LINE_B);
      send(32'h9876_FEDC);
      n = 0;
      while (!(tx_cnt == base + 10 && dbg_state == ST_DONE && txempty) && n < 5000) begin
         @(negedge clk); n++;
      end
      if (n >= 5000) check("line_b_end_timeout", 32'd1, 32'd0);
      value = 32'h0000_0000; valid = 1'b1;
      push_line(LINE_C);
      @(negedge clk);
      check("busy_fell", busy, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      check("accept_next_cycle", dbg_state, ST_ISSUE);
      @(negedge clk);
      check("first_byte_latency", tx_en, 1'b1);
      repeat (2) @(negedge clk);
      check("drop_on_return", drop_cnt, 2);
      wait_idle(5000, "line_c_timeout");
      check("line_bc_count", tx_cnt, base + 20);

      // transmitter held busy externally: no load until released
      hold = 1'b1;
      base = tx_cnt;
      push_line(LINE_D);
      send(32'h0F1E_2D3C);
      repeat (50) @(negedge clk);
      check("hold_no_tx_en", tx_cnt, base);
      check("hold_state_issue", dbg_state, ST_ISSUE);
      hold = 1'b0;
      repeat (3) @(negedge clk);
      check("release_one_load", tx_cnt, base + 1);
      wait_idle(5000, "line_d_timeout");
      check("line_d_count", tx_cnt, base + 10);

      // reset mid-line aborts; the next request sends a whole line
      base = tx_cnt;
      push_line(LINE_A);
      send(32'h1234_ABCD);
      wait_cnt(base + 3, 5000, "third_byte_timeout");
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_drop", drop, 1'b0);
      check("mid_rst_tx_en", tx_en, 1'b0);
      check("mid_rst_tx_data", tx_data, 8'h00);
      check("mid_rst_state", dbg_state, ST_IDLE);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_resume", busy, 1'b0);
      base = tx_cnt;
      push_line(LINE_A);
      send(32'h1234_ABCD);
      wait_idle(5000, "line_after_rst_timeout");
      check("line_after_rst_count", tx_cnt, base + 10);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_hex_sender.md
UART_HEX_SENDER -- requirements
Module: uart_hex_sender

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, meaning the number of hex digits sent per line (1..8).
REQ-002 SHALL have parameter APPEND_CRLF, default 1, meaning 1 appends 0x0D,0x0A after the digits and 0 sends no terminator.
REQ-003 SHALL have port i_clk  input  1  system clock (50 MHz); one clock only; reset is asynchronous and active-low.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_value  input  32  measurement word; the low NIBBLES*4 bits are sent.
REQ-006 SHALL have port i_valid  input  1  one-cycle strobe requesting transmission of i_value.
REQ-007 SHALL have port o_busy  output  1  high while a line is in progress.
REQ-008 SHALL have port o_drop  output  1  one-cycle pulse when i_valid arrives while busy.
REQ-009 SHALL have port o_tx_data  output  8  byte presented to the UART transmitter.
REQ-010 SHALL have port o_tx_en  output  1  one-cycle byte-load strobe to the UART transmitter.
REQ-011 SHALL have port i_txempty  input  1  transmitter idle flag; it falls the cycle after a load and rises when the stop bit ends.

Function
REQ-012 SHALL implement an FSM with states IDLE, ISSUE, ACK and DONE.
REQ-013 IDLE: i_valid=1 SHALL latch i_value and set char index to 0, go to ISSUE and raise o_busy at the same edge.
REQ-014 ISSUE: if i_txempty=1, it SHALL register o_tx_data=char[index] and o_tx_en=1 and go to ACK; otherwise it SHALL stay in ISSUE.
REQ-015 o_tx_en SHALL be high for exactly one cycle per byte and SHALL be cleared on the edge after it is set.
REQ-016 o_tx_data SHALL hold stable from o_tx_en assertion until the next byte is issued.
REQ-017 ACK: the FSM SHALL wait for i_txempty=0 and then go to DONE; the i_txempty=1 seen in the cycle o_tx_en is high SHALL NOT count.
REQ-018 DONE: the FSM SHALL wait for i_txempty=1; then if index is the last index it SHALL go to IDLE and clear o_busy, otherwise it SHALL increment index and go to ISSUE.
REQ-019 Character order SHALL be the most significant nibble first, then CR, then LF.
REQ-020 The last index SHALL be NIBBLES-1+2*APPEND_CRLF; the index counter SHALL be 4 bits and SHALL never wrap.
REQ-021 Nibble encoding SHALL map 0..9 to 0x30..0x39 and 10..15 to 0x41..0x46 (uppercase).
REQ-022 i_valid SHALL be accepted only in IDLE; in any other state it SHALL be ignored, the latched word SHALL stay unchanged and o_drop SHALL pulse one cycle later.
REQ-023 i_valid in the same cycle the FSM returns to IDLE SHALL be dropped; it is accepted only from the following cycle.
REQ-024 Latency SHALL be: i_valid sampled at edge k with i_txempty=1 gives o_tx_en high in the cycle after edge k+1.
REQ-025 Between bytes, o_tx_en SHALL be issued on the edge after i_txempty rises plus one state step, with no other added delay.
REQ-026 o_busy SHALL be low in IDLE only.

Reset
REQ-027 On reset the outputs SHALL be: o_busy=0, o_drop=0, o_tx_en=0, o_tx_data=0x00.
REQ-028 On reset the state SHALL be IDLE, the index 0 and the latched word 0.
REQ-029 Reset asserted mid-line SHALL abort immediately; on release the block SHALL be idle, and no partial-line resume SHALL occur.

Structure
REQ-030 The shared package uart_pkg SHALL hold the state encoding localparams and the ASCII constants ASCII_0, ASCII_A, ASCII_CR and ASCII_LF.
REQ-031 Nibble-to-ASCII conversion SHALL be one combinational sub-module named hex_nibble_ascii.
REQ-032 All sequential logic SHALL use a single clock domain with asynchronous active-low reset.

Verification
REQ-033 The bench SHALL connect a behavioural UART transmitter model (10 bits x 434 clocks).
REQ-034 i_value=0x1234ABCD, i_valid pulse -> bytes 31 32 33 34 41 42 43 44 0D 0A; exactly ten o_tx_en pulses; then o_busy falls.
REQ-035 NIBBLES=4, APPEND_CRLF=0, i_value=0x0000F00F -> bytes 46 30 30 46 only.
REQ-036 A second i_valid 100 cycles after the first -> o_drop one pulse; output identical to the first line only.
REQ-037 i_valid on the cycle o_busy falls -> dropped; i_valid one cycle later -> accepted, and its first byte is issued within 2 cycles.
REQ-038 Hold i_txempty=0 externally at start -> FSM stays in ISSUE with no o_tx_en; release -> o_tx_en exactly once.
REQ-039 Assert i_rst_n low after the 3rd byte -> all outputs at reset values; a new i_valid after release -> the full line is sent from the first digit.
